mont_mul_ws: RTL and testbench

- Parametrised, word-serial radix-2 Montgomery multiplier.
- Computes R = A·B·2^-K mod N with K = WORD_W·NUM_WORDS.
- Operands A, B and N are streamed in one word per cycle, least-significant word first. The result is streamed back out with valid/ready backpressure.
- Core building block for the RSA modular-exponentiation controller, which issues repeated square/multiply calls. It replaces the fixed 32-bit/1024-bit product stage.

---
 rtl/mont_pkg.sv | 24 ++
 rtl/mont_step.sv | 27 ++
 rtl/mont_mul_ws.sv | 146 ++++++++++++++
 tb/tb_mont_mul_ws.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the word-serial Montgomery multiplier: FSM state
// encoding and the helpers that derive operand width and counter width.
package mont_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_FINAL = 3'd3,
    ST_OUT   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Operand width in bits: one Montgomery iteration per bit.
  function automatic int calc_k(input int word_w, input int num_words);
    return word_w * num_words;
  endfunction

  // Counter width wide enough to hold every bit index and word index.
  function automatic int calc_cnt_w(input int word_w, input int num_words);
    return $clog2(word_w * num_words) + 1;
  endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration, purely combinational:
//   T = S + a_i*B ; if T odd then T += N ; S' = T/2
// Kept standalone so the adder chain can be swapped for a radix-4 step.
module mont_step #(
  parameter int K = 16
) (
  input  logic [K:0]   s,
  input  logic [K-1:0] b,
  input  logic [K-1:0] n,
  input  logic         a_bit,
  output logic [K:0]   s_next
);

  logic [K+1:0] t_ab;
  logic         q;
  logic [K:0]   n_half;

  // Partial product accumulation on the full K+2-bit width.
  assign t_ab = {1'b0, s} + (a_bit ? {2'b00, b} : '0);
  assign q    = t_ab[0];

  // (T + q*N) is even, so halve before the N addition: the only bit that
  // crosses the dropped LSB is the carry T[0]&N[0] when the correction fires.
  assign n_half = q ? {2'b00, n[K-1:1]} : '0;
  assign s_next = t_ab[K+1:1] + n_half + {{K{1'b0}}, q & n[0]};

endmodule

// File: rtl/mont_mul_ws.sv
// Word-serial radix-2 Montgomery multiplier: R = A*B*2^-K mod N.
// Operands stream in LS word first, K iterations run one per cycle, a final
// conditional subtraction brings S below N, then S streams out LS word first.
module mont_mul_ws
  import mont_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  input  logic [WORD_W-1:0] n_in,
  output logic [WORD_W-1:0] res_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err_even_n,
  output logic [2:0]        state_out
);

  localparam int K     = calc_k(WORD_W, NUM_WORDS);
  localparam int CNT_W = calc_cnt_w(WORD_W, NUM_WORDS);

  state_t             state_q, state_d;
  logic [K-1:0]       a_q, b_q, n_q;
  logic [K:0]         s_q, s_step;
  logic [CNT_W-1:0]   cnt_q;
  logic [K-1:0]       n_shift;
  logic               load_done;
  logic               cnt_last_word;
  logic               cnt_last_bit;

  // N as it will look after the current word is shifted in; its bit 0 decides
  // the odd-modulus check on the final load edge.
  assign n_shift       = {n_in, n_q[K-1:WORD_W]};
  assign cnt_last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));
  assign cnt_last_bit  = (cnt_q == CNT_W'(K - 1));
  assign load_done     = (state_q == ST_LOAD) && in_valid && cnt_last_word;
  assign state_out     = state_q;

  mont_step #(.K(K)) u_step (
    .s      (s_q),
    .b      (b_q),
    .n      (n_q),
    .a_bit  (a_q[0]),
    .s_next (s_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    err_even_n = 1'b0;
    res_out    = '0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (load_done) state_d = n_shift[0] ? ST_CALC : ST_ERR;
      end
      ST_CALC: begin
        if (cnt_last_bit) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        res_out   = s_q[WORD_W-1:0];
        out_last  = cnt_last_word;
        if (out_ready && cnt_last_word) state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_even_n = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand shift registers, accumulator S and the shared word/bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) cnt_q <= '0;
        end
        ST_LOAD: begin
          if (in_valid) begin
            a_q   <= {a_in, a_q[K-1:WORD_W]};
            b_q   <= {b_in, b_q[K-1:WORD_W]};
            n_q   <= n_shift;
            s_q   <= '0;
            cnt_q <= cnt_last_word ? '0 : cnt_q + CNT_W'(1);
          end
        end
        ST_CALC: begin
          s_q   <= s_step;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_last_bit ? '0 : cnt_q + CNT_W'(1);
        end
        ST_FINAL: begin
          if (s_q >= {1'b0, n_q}) s_q <= s_q - {1'b0, n_q};
          cnt_q <= '0;
        end
        ST_OUT: begin
          if (out_ready) begin
            s_q   <= s_q >> WORD_W;
            cnt_q <= cnt_last_word ? '0 : cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_ws.sv
// Directed bench for mont_mul_ws: a small instance (8-bit words, 2 words,
// K=16, N=251, R mod N = 25) and a default-parameter 1024-bit instance.
module tb_mont_mul_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Small instance
  logic       reset, start, in_valid, out_ready;
  logic [7:0] a_in, b_in, n_in;
  logic [7:0] res_out;
  logic       in_ready, out_valid, out_last, busy, err_even_n;
  logic [2:0] state_out;

  mont_mul_ws #(.WORD_W(8), .NUM_WORDS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .n_in(n_in),
    .res_out(res_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err_even_n(err_even_n),
    .state_out(state_out)
  );

  // Default-parameter instance
  logic        d_reset, d_start, d_in_valid, d_out_ready;
  logic [31:0] d_a, d_b, d_n, d_res;
  logic        d_in_ready, d_out_valid, d_out_last, d_busy, d_err;
  logic [2:0]  d_state;

  mont_mul_ws dut_big (
    .clk(clk), .reset(d_reset), .start(d_start), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .a_in(d_a), .b_in(d_b), .n_in(d_n),
    .res_out(d_res), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_last(d_out_last), .busy(d_busy), .err_even_n(d_err),
    .state_out(d_state)
  );

  // Issue start, then stream two words per operand; gaps toggles in_valid.
  task automatic do_load(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] n, input bit gaps, output bit ok);
    int  w;
    int  guard;
    bit  phase;
    bit  acc;
    w = 0; guard = 0; phase = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (w < 2 && guard < 40) begin
      in_valid = gaps ? phase : 1'b1;
      if (in_valid) begin
        a_in = a[w*8 +: 8]; b_in = b[w*8 +: 8]; n_in = n[w*8 +: 8];
      end else begin
        a_in = 8'hFF; b_in = 8'hFF; n_in = 8'hFE;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) w++;
      phase = ~phase;
      guard++;
    end
    in_valid = 1'b0;
    ok = (w == 2);
  endtask

  // Count edges until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drain both result words; holds out_ready low for 'hold' cycles first.
  task automatic collect(input int hold, output logic [7:0] w0, output logic [7:0] w1,
                         output logic l0, output logic l1, output bit stable);
    logic [7:0] first;
    stable = 1'b1;
    first = res_out;
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (res_out !== first || out_valid !== 1'b1 || out_last !== 1'b0) stable = 1'b0;
    end
    w0 = res_out; l0 = out_last;
    out_ready = 1'b1;
    @(posedge clk); #1;
    w1 = res_out; l1 = out_last;
    if (out_valid !== 1'b1) stable = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; d_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({state_out, in_ready, out_valid, out_last, busy, err_even_n, res_out} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_small: got %h want 0000",
               {state_out, in_ready, out_valid, out_last, busy, err_even_n, res_out});
    end
    n_cmp++;
    if ({d_state, d_in_ready, d_out_valid, d_out_last, d_busy, d_err, d_res} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_big: got %h want 0",
               {d_state, d_in_ready, d_out_valid, d_out_last, d_busy, d_err, d_res});
    end
    reset = 1'b0; d_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic [7:0] e0, input logic [7:0] e1, input bit gaps,
                               input int hold);
    bit ok, stable;
    int lat;
    logic [7:0] w0, w1;
    logic l0, l1;
    do_load(a, b, 16'h00FB, gaps, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL %s_load: got %0d words want 2", tag, ok); end
    wait_out(lat);
    n_cmp++;
    if (lat !== 17) begin n_bad++; $display("FAIL %s_latency: got %0d want 17", tag, lat); end
    collect(hold, w0, w1, l0, l1, stable);
    n_cmp++;
    if (w0 !== e0) begin n_bad++; $display("FAIL %s_w0: got %h want %h", tag, w0, e0); end
    n_cmp++;
    if (w1 !== e1) begin n_bad++; $display("FAIL %s_w1: got %h want %h", tag, w1, e1); end
    n_cmp++;
    if ({l0, l1} !== 2'b01) begin n_bad++; $display("FAIL %s_last: got %b want 01", tag, {l0, l1}); end
    n_cmp++;
    if (stable !== 1'b1) begin n_bad++; $display("FAIL %s_stable: got %b want 1", tag, stable); end
    n_cmp++;
    if ({state_out, busy, out_valid} !== 5'b0) begin
      n_bad++; $display("FAIL %s_idle: got %b want 00000", tag, {state_out, busy, out_valid});
    end
  endtask

  task automatic test_even_n();
    bit ok;
    do_load(16'h0005, 16'h0003, 16'h00FA, 1'b0, ok);
    n_cmp++;
    if ({err_even_n, state_out, out_valid, busy} !== 6'b1_101_0_1) begin
      n_bad++; $display("FAIL even_err_cycle: got %b want 110101", {err_even_n, state_out, out_valid, busy});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({err_even_n, state_out, out_valid, busy} !== 6'b0) begin
      n_bad++; $display("FAIL even_after: got %b want 000000", {err_even_n, state_out, out_valid, busy});
    end
    test_identity("after_err", 16'h0019, 16'h0005, 8'h05, 8'h00, 1'b0, 0);
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    do_load(16'h0019, 16'h0005, 16'h00FB, 1'b0, ok);
    repeat (7) @(posedge clk);
    #1;
    n_cmp++;
    if (state_out !== 3'd2) begin n_bad++; $display("FAIL midcalc_state: got %0d want 2", state_out); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({state_out, in_ready, out_valid, out_last, busy, err_even_n, res_out} !== 16'h0) begin
      n_bad++;
      $display("FAIL midcalc_reset: got %h want 0000",
               {state_out, in_ready, out_valid, out_last, busy, err_even_n, res_out});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    test_identity("post_reset", 16'h0019, 16'h0005, 8'h05, 8'h00, 1'b0, 0);
  endtask

  task automatic test_default_1024();
    logic [1023:0] nbig, abig, res_big;
    logic [1024:0] r;
    int lat;
    bit last_ok;
    nbig = {32{32'hDEADBEEF}};
    r = 1025'd1;
    for (int i = 0; i < 1024; i++) begin
      r = r << 1;
      if (r >= {1'b0, nbig}) r = r - {1'b0, nbig};
    end
    abig = r[1023:0];
    res_big = '0;
    last_ok = 1'b1;
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    for (int w = 0; w < 32; w++) begin
      d_in_valid = 1'b1;
      d_a = abig[w*32 +: 32];
      d_b = (w == 0) ? 32'd1 : 32'd0;
      d_n = nbig[w*32 +: 32];
      @(posedge clk); #1;
    end
    d_in_valid = 1'b0;
    lat = 0;
    while (!d_out_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 1025) begin n_bad++; $display("FAIL big_latency: got %0d want 1025", lat); end
    d_out_ready = 1'b1;
    for (int w = 0; w < 32; w++) begin
      res_big[w*32 +: 32] = d_res;
      if (d_out_valid !== 1'b1 || d_out_last !== (w == 31)) last_ok = 1'b0;
      @(posedge clk); #1;
    end
    d_out_ready = 1'b0;
    n_cmp++;
    if (res_big !== 1024'd1) begin
      n_bad++; $display("FAIL big_result: got low word %h want 1024'd1", res_big[31:0]);
    end
    n_cmp++;
    if (last_ok !== 1'b1) begin n_bad++; $display("FAIL big_handshake: got %b want 1", last_ok); end
    n_cmp++;
    if ({d_state, d_busy} !== 4'b0) begin
      n_bad++; $display("FAIL big_idle: got %b want 0000", {d_state, d_busy});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; n_in = '0;
    d_reset = 1'b1; d_start = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
    d_a = '0; d_b = '0; d_n = '0;
    test_reset();
    test_identity("identity", 16'h0019, 16'h0005, 8'h05, 8'h00, 1'b0, 0);
    test_identity("rr",       16'h0019, 16'h0019, 8'h19, 8'h00, 1'b0, 0);
    test_identity("zero",     16'h0000, 16'h0019, 8'h00, 8'h00, 1'b0, 0);
    test_even_n();
    test_identity("handshake", 16'h0019, 16'h0005, 8'h05, 8'h00, 1'b1, 5);
    test_reset_mid_calc();
    test_default_1024();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
